// File: rtl/ddr3_dma_pkg.sv
// Shared definitions for the DDR3 DMA read client.
// Contents: bus widths of the DMA engine port, the client FSM state
// encoding, and the burst-sizing rule that both the request side and the
// receive-side framing check rely on.
package ddr3_dma_pkg;

    localparam int DMA_ADDR_W = 27;
    localparam int DMA_DATA_W = 512;
    localparam int DMA_LEN_W  = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SIZE  = 2'd1,
        ST_REQ   = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_e;

    // Length of the next burst given the words still to fetch. Splitting
    // MAX_BURST+1 as (MAX_BURST-1, 2) keeps every burst at two words or more.
    // Requests and received data are both sliced with this same rule, so the
    // receive side can re-derive each burst length from its own word count.
    function automatic logic [DMA_LEN_W-1:0] burst_len(
        input logic [DMA_LEN_W-1:0] rem,
        input logic [DMA_LEN_W-1:0] max_burst
    );
        if (rem <= max_burst)
            return rem;
        else if (rem == max_burst + DMA_LEN_W'(1))
            return max_burst - DMA_LEN_W'(1);
        else
            return max_burst;
    endfunction

endpackage

// File: rtl/rd_client_buf_fifo.sv
// Synchronous WIDTH x DEPTH FIFO with show-ahead read data.
// Ports: clk/rst (sync, active high); wr_en/wr_data push; rd_en pop;
// rd_data is the head word; count is occupancy; empty flags count == 0.
// Writes into a full FIFO and reads from an empty FIFO are ignored.
module rd_client_buf_fifo
    import ddr3_dma_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = DMA_DATA_W,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_dma_read_client.sv
// One requester slot of the DDR3 DMA read engine.
// Takes a job (job_addr/job_length in 512-bit words), slices it into bursts,
// issues them on read_req/read_start_addr/read_length (read_ack handshake),
// buffers returned words qualified by dma_en, and replays them as an
// OUT_WIDTH-bit valid/ready stream on m_data/m_valid/m_ready/m_last.
// job_done pulses with the acceptance of the final lane; err_eop is a sticky
// flag for dma_eop not lining up with the last beat of a burst.
//
// state | meaning
// IDLE  | waiting for a job offer (job_ready high)
// SIZE  | size next burst, wait for enough uncommitted buffer space
// REQ   | read_req high until read_ack
// DRAIN | all bursts issued, wait for data in and last lane out
module ddr3_dma_read_client
    import ddr3_dma_pkg::*;
#(
    parameter int OUT_WIDTH = 64,
    parameter int BUF_DEPTH = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [DMA_ADDR_W-1:0] job_addr,
    input  logic [DMA_LEN_W-1:0]  job_length,
    output logic                  job_done,
    output logic                  read_req,
    output logic [DMA_ADDR_W-1:0] read_start_addr,
    output logic [DMA_LEN_W-1:0]  read_length,
    input  logic                  read_ack,
    input  logic [DMA_DATA_W-1:0] dma_data,
    input  logic                  dma_en,
    input  logic                  dma_eop,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  err_eop
);

    localparam int LANES  = DMA_DATA_W / OUT_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam logic [DMA_LEN_W-1:0] ONE     = DMA_LEN_W'(1);
    localparam logic [DMA_LEN_W-1:0] MAX_B_L = DMA_LEN_W'(MAX_BURST);
    localparam logic [DMA_LEN_W-1:0] DEPTH_L = DMA_LEN_W'(BUF_DEPTH);

    rd_state_e             state_q, state_d;
    logic [DMA_ADDR_W-1:0] addr_q;
    logic [DMA_LEN_W-1:0]  rem_q, len_q, outst_q;
    logic [DMA_LEN_W-1:0]  rx_rem_q, rx_left_q, rx_left_nxt;
    logic [DMA_LEN_W-1:0]  wcnt_q, cur_idx_q;
    logic [DMA_LEN_W-1:0]  burst_c, free_c;
    logic [CNT_W-1:0]      occ;
    logic                  buf_empty;
    logic [DMA_DATA_W-1:0] buf_rd_data, word_q;
    logic [LANE_W-1:0]     lane_q;
    logic job_take, issue, ack_fire, capture, cap_dec;
    logic load_ok, pop, last_hs, last_acc_q, done_c;

    assign job_take = (state_q == ST_IDLE) & job_valid;
    assign burst_c  = burst_len(rem_q, MAX_B_L);
    // Space not yet claimed by buffered words or by words still in flight.
    assign free_c   = DEPTH_L - (DMA_LEN_W'(occ) + outst_q);
    assign issue    = (state_q == ST_SIZE) && (free_c >= burst_c);
    assign ack_fire = (state_q == ST_REQ) & read_ack;
    // Beats seen in IDLE belong to an abandoned job and are dropped.
    assign capture  = dma_en & (state_q != ST_IDLE);
    assign cap_dec  = capture & (outst_q != '0);
    assign load_ok  = ~m_valid | m_ready;
    assign pop      = load_ok & (lane_q == '0) & ~buf_empty;
    assign last_hs  = m_valid & m_ready & m_last;
    assign done_c   = (outst_q == '0) & buf_empty & (last_acc_q | last_hs);
    // Beats left in the current receive burst after this one.
    assign rx_left_nxt = ((rx_left_q == '0) ? burst_len(rx_rem_q, MAX_B_L)
                                            : rx_left_q) - ONE;

    rd_client_buf_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DMA_DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (dma_data),
        .rd_en   (pop),
        .rd_data (buf_rd_data),
        .count   (occ),
        .empty   (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (job_valid) state_d = ST_SIZE;
            ST_SIZE:  if (issue) state_d = ST_REQ;
            ST_REQ:   if (read_ack) state_d = (rem_q == read_length) ? ST_DRAIN : ST_SIZE;
            ST_DRAIN: if (done_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        job_ready = (state_q == ST_IDLE) & ~rst;
        read_req  = (state_q == ST_REQ);
        job_done  = (state_q == ST_DRAIN) & done_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            rem_q           <= '0;
            len_q           <= '0;
            outst_q         <= '0;
            rx_rem_q        <= '0;
            rx_left_q       <= '0;
            read_start_addr <= '0;
            read_length     <= '0;
            err_eop         <= 1'b0;
            last_acc_q      <= 1'b0;
        end else begin
            if (job_take) begin
                addr_q     <= job_addr;
                rem_q      <= job_length;
                len_q      <= job_length;
                rx_rem_q   <= job_length;
                rx_left_q  <= '0;
                last_acc_q <= 1'b0;
            end
            if (issue) begin
                read_start_addr <= addr_q;
                read_length     <= burst_c;
            end
            if (ack_fire) begin
                addr_q <= addr_q + read_length;
                rem_q  <= rem_q - read_length;
            end
            outst_q <= outst_q + (ack_fire ? read_length : '0) - (cap_dec ? ONE : '0);
            if (capture) begin
                if ((dma_eop != (rx_left_nxt == '0)) || (rx_rem_q == '0))
                    err_eop <= 1'b1;
                rx_left_q <= rx_left_nxt;
                if (rx_rem_q != '0)
                    rx_rem_q <= rx_rem_q - ONE;
            end
            if (last_hs)
                last_acc_q <= 1'b1;
        end
    end

    // Serializer: word_q holds the not-yet-emitted lanes of the current word,
    // shifted down so the next lane is always in the low bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            word_q    <= '0;
            lane_q    <= '0;
            wcnt_q    <= '0;
            cur_idx_q <= '0;
        end else begin
            if (job_take) begin
                wcnt_q    <= '0;
                cur_idx_q <= '0;
            end
            if (load_ok) begin
                if (lane_q == '0) begin
                    if (!buf_empty) begin
                        m_data    <= buf_rd_data[OUT_WIDTH-1:0];
                        word_q    <= buf_rd_data >> OUT_WIDTH;
                        m_valid   <= 1'b1;
                        m_last    <= (LANES == 1) && (wcnt_q == len_q - ONE);
                        cur_idx_q <= wcnt_q;
                        wcnt_q    <= wcnt_q + ONE;
                        lane_q    <= (LANES == 1) ? '0 : LANE_W'(1);
                    end else begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                end else begin
                    m_data  <= word_q[OUT_WIDTH-1:0];
                    word_q  <= word_q >> OUT_WIDTH;
                    m_valid <= 1'b1;
                    m_last  <= (lane_q == LANE_W'(LANES - 1)) && (cur_idx_q == len_q - ONE);
                    lane_q  <= (lane_q == LANE_W'(LANES - 1)) ? '0 : lane_q + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_dma_read_client.sv
// Directed bench for ddr3_dma_read_client (OUT_WIDTH=64, BUF_DEPTH=32,
// MAX_BURST=16). The initial block plays the DMA engine and the job source;
// a negedge monitor records accepted lanes and job_done pulses.
module tb_ddr3_dma_read_client;

    localparam int OW = 64;
    localparam int BUF_DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [26:0]  job_addr = '0;
    logic [26:0]  job_length = '0;
    logic         job_done;
    logic         read_req;
    logic [26:0]  read_start_addr;
    logic [26:0]  read_length;
    logic         read_ack = 1'b0;
    logic [511:0] dma_data = '0;
    logic         dma_en = 1'b0;
    logic         dma_eop = 1'b0;
    logic [OW-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         m_last;
    logic         err_eop;

    int nvec = 0;
    int nfail = 0;
    int done_cnt = 0;
    bit overflow_seen = 1'b0;
    logic [OW-1:0] got_q[$];
    logic          lastf_q[$];
    logic [OW-1:0] exp_q[$];

    ddr3_dma_read_client #(.OUT_WIDTH(OW), .BUF_DEPTH(BUF_DEPTH), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_addr(job_addr), .job_length(job_length), .job_done(job_done),
        .read_req(read_req), .read_start_addr(read_start_addr), .read_length(read_length),
        .read_ack(read_ack), .dma_data(dma_data), .dma_en(dma_en), .dma_eop(dma_eop),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .err_eop(err_eop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                lastf_q.push_back(m_last);
            end
            if (job_done)
                done_cnt++;
            if (dma_en && int'(dut.occ) >= BUF_DEPTH)
                overflow_seen = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_word(input logic [26:0] a);
        logic [511:0] w;
        for (int k = 0; k < 8; k++)
            w[k*64 +: 64] = {32'(a) ^ 32'hDEAD_0000, 32'(k) ^ 32'h5A5A_0000};
        return w;
    endfunction

    task automatic start_job(input logic [26:0] a, input logic [26:0] l);
        int n = 0;
        while (job_ready !== 1'b1 && n < 200) begin tick; n++; end
        chk("job_ready", 64'(job_ready), 64'(1));
        job_addr = a; job_length = l; job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
    endtask

    // Wait for one request, check it, hold off the ack, then return beats.
    task automatic serve(input logic [26:0] a, input logic [26:0] l, input int ack_dly,
                         input int eop_idx, input int nbeats, input bit chk_lat);
        int n = 0;
        bit stable = 1'b1;
        logic [511:0] w;
        while (read_req !== 1'b1 && n < 300) begin tick; n++; end
        chk("req_seen", 64'(read_req), 64'(1));
        chk("req_addr", 64'(read_start_addr), 64'(a));
        chk("req_len", 64'(read_length), 64'(l));
        for (int d = 0; d < ack_dly; d++) begin
            tick;
            if (read_req !== 1'b1 || read_start_addr !== a || read_length !== l)
                stable = 1'b0;
        end
        chk("req_stable", 64'(stable), 64'(1));
        read_ack = 1'b1;
        tick;
        read_ack = 1'b0;
        chk("req_drop", 64'(read_req), 64'(0));
        chk("addr_hold", 64'(read_start_addr), 64'(a));
        for (int i = 0; i < nbeats; i++) begin
            w = mk_word(a + 27'(i));
            dma_data = w; dma_en = 1'b1; dma_eop = (i == eop_idx);
            for (int k = 0; k < 8; k++) exp_q.push_back(w[k*64 +: 64]);
            tick;
            if (chk_lat && i == 0) chk("lat_1cyc", 64'(m_valid), 64'(0));
            if (chk_lat && i == 1) chk("lat_2cyc", 64'(m_valid), 64'(1));
        end
        dma_en = 1'b0; dma_eop = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt - base < 1 && n < 2000) begin tick; n++; end
        repeat (3) tick;
        chk("done_pulses", 64'(done_cnt - base), 64'(1));
    endtask

    task automatic check_stream(input int gb, input int eb, input int n);
        int errs = 0;
        int nl = 0;
        int lp = -1;
        chk("lane_count", 64'(got_q.size() - gb), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (gb + i < got_q.size() && eb + i < exp_q.size()) begin
                if (got_q[gb+i] !== exp_q[eb+i]) errs++;
            end else errs++;
        end
        for (int i = gb; i < got_q.size(); i++)
            if (lastf_q[i]) begin nl++; lp = i - gb; end
        chk("lane_data", 64'(errs), 64'(0));
        chk("last_count", 64'(nl), 64'(1));
        chk("last_pos", 64'(lp), 64'(n - 1));
    endtask

    initial begin
        int gb, eb, db, seen;

        // Reset
        repeat (3) tick;
        chk("rst_job_ready", 64'(job_ready), 64'(0));
        chk("rst_read_req", 64'(read_req), 64'(0));
        rst = 1'b0;
        tick;
        chk("idle_job_ready", 64'(job_ready), 64'(1));
        chk("idle_m_valid", 64'(m_valid), 64'(0));
        chk("idle_len", 64'(read_length), 64'(0));
        chk("idle_err", 64'(err_eop), 64'(0));

        // Single 4-word job
        gb = got_q.size(); eb = exp_q.size(); db = done_cnt;
        start_job(27'h100, 27'd4);
        serve(27'h100, 27'd4, 0, 3, 4, 1'b1);
        wait_done(db);
        check_stream(gb, eb, 32);

        // 17 words: 15 + 2
        gb = got_q.size(); eb = exp_q.size(); db = done_cnt;
        start_job(27'h2000, 27'd17);
        serve(27'h2000, 27'd15, 0, 14, 15, 1'b0);
        serve(27'h200F, 27'd2, 0, 1, 2, 1'b0);
        wait_done(db);
        check_stream(gb, eb, 136);

        // 40 words with backpressure: third burst withheld until space frees
        gb = got_q.size(); eb = exp_q.size(); db = done_cnt;
        m_ready = 1'b0;
        start_job(27'h4000, 27'd40);
        serve(27'h4000, 27'd16, 0, 15, 16, 1'b0);
        serve(27'h4010, 27'd16, 0, 15, 16, 1'b0);
        seen = 0;
        repeat (20) begin tick; if (read_req === 1'b1) seen++; end
        chk("withheld_req", 64'(seen), 64'(0));
        chk("hold_valid", 64'(m_valid), 64'(1));
        chk("hold_data", m_data, exp_q[eb]);
        m_ready = 1'b1;
        serve(27'h4020, 27'd8, 0, 7, 8, 1'b0);
        wait_done(db);
        check_stream(gb, eb, 320);

        // Delayed ack
        gb = got_q.size(); eb = exp_q.size(); db = done_cnt;
        start_job(27'h6000, 27'd6);
        serve(27'h6000, 27'd6, 10, 5, 6, 1'b0);
        seen = 0;
        repeat (10) begin tick; if (read_req === 1'b1) seen++; end
        chk("extra_req", 64'(seen), 64'(0));
        wait_done(db);
        check_stream(gb, eb, 48);
        chk("err_clean", 64'(err_eop), 64'(0));

        // Early eop on beat 3 of 4
        gb = got_q.size(); eb = exp_q.size(); db = done_cnt;
        start_job(27'h8000, 27'd4);
        serve(27'h8000, 27'd4, 0, 2, 4, 1'b0);
        chk("err_set", 64'(err_eop), 64'(1));
        wait_done(db);
        check_stream(gb, eb, 32);
        chk("err_sticky", 64'(err_eop), 64'(1));

        // Reset with 5 words outstanding
        start_job(27'hA000, 27'd8);
        serve(27'hA000, 27'd8, 0, 7, 3, 1'b0);
        rst = 1'b1;
        tick;
        chk("mid_rst_req", 64'(read_req), 64'(0));
        chk("mid_rst_addr", 64'(read_start_addr), 64'(0));
        chk("mid_rst_len", 64'(read_length), 64'(0));
        chk("mid_rst_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_last", 64'(m_last), 64'(0));
        chk("mid_rst_err", 64'(err_eop), 64'(0));
        chk("mid_rst_done", 64'(job_done), 64'(0));
        chk("mid_rst_ready", 64'(job_ready), 64'(0));
        rst = 1'b0;
        dma_data = mk_word(27'hA003); dma_en = 1'b1;
        repeat (2) tick;
        dma_en = 1'b0;
        repeat (4) tick;
        chk("stray_dropped", 64'(m_valid), 64'(0));
        gb = got_q.size(); eb = exp_q.size(); db = done_cnt;
        start_job(27'hC000, 27'd3);
        serve(27'hC000, 27'd3, 0, 2, 3, 1'b0);
        wait_done(db);
        check_stream(gb, eb, 24);
        chk("no_overflow", 64'(overflow_seen), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
